// File: rtl/rom_fetch_unit_if.sv
// Bus bundle between the ROM fetch unit, the program ROM and the core.
// master = fetch unit side, slave = ROM/core side.
interface rom_fetch_unit_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] ROM_ADDR;
    logic [DATA_WIDTH-1:0] ROM_DATA;
    logic                  ENABLE;
    logic                  JUMP;
    logic [ADDR_WIDTH-1:0] JUMP_ADDR;
    logic [DATA_WIDTH-1:0] OUT_DATA;
    logic [ADDR_WIDTH-1:0] OUT_ADDR;
    logic                  OUT_VALID;
    logic                  OUT_READY;

    modport master (
        output ROM_ADDR,
        input  ROM_DATA,
        input  ENABLE,
        input  JUMP,
        input  JUMP_ADDR,
        output OUT_DATA,
        output OUT_ADDR,
        output OUT_VALID,
        input  OUT_READY
    );

    modport slave (
        input  ROM_ADDR,
        output ROM_DATA,
        output ENABLE,
        output JUMP,
        output JUMP_ADDR,
        input  OUT_DATA,
        input  OUT_ADDR,
        input  OUT_VALID,
        output OUT_READY
    );
endinterface

// File: rtl/rom_fetch_unit.sv
// Sequential prefetcher for the program ROM: issues addresses, captures 1-cycle
// latency read data into an address-tagged FIFO and hands bytes to the core.
//
// state | meaning
// IDLE  | no new ROM reads issued; buffered bytes remain poppable
// RUN   | issue one read per cycle while FIFO credit is available
module rom_fetch_unit #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    rom_fetch_unit_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  pending;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [ADDR_WIDTH-1:0] tag;
    logic [CW-1:0]         count;
    logic [CW-1:0]         credit;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A pop in the same cycle is not credited, so the in-flight byte always has a slot.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        credit    = count + CW'(pending);
        case (state)
            IDLE:    if (bus.ENABLE)  state_nxt = RUN;
            RUN:     if (!bus.ENABLE) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        issue = (state == RUN) && (credit < DEPTH_C) && !bus.JUMP;
        push  = pending && !bus.JUMP;
        pop   = out_valid && bus.OUT_READY && !bus.JUMP;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rom_addr <= RESET_ADDR;
            tag      <= '0;
            pending  <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (bus.JUMP) begin
            rom_addr <= bus.JUMP_ADDR;
            pending  <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            pending <= issue;
            if (issue) begin
                tag      <= rom_addr;
                rom_addr <= rom_addr + ADDR_WIDTH'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Entry storage needs no reset; stale entries are masked by count.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_data[wr_ptr] <= bus.ROM_DATA;
            mem_addr[wr_ptr] <= tag;
        end
    end

    assign out_valid     = (count != '0);
    assign bus.OUT_VALID = out_valid;
    assign bus.OUT_DATA  = out_valid ? mem_data[rd_ptr] : '0;
    assign bus.OUT_ADDR  = out_valid ? mem_addr[rd_ptr] : '0;
    assign bus.ROM_ADDR  = rom_addr;
endmodule

// File: tb/tb_rom_fetch_unit.sv
// Directed bench for rom_fetch_unit: ROM model with 1-cycle latency and a
// scoreboard of expected {addr,data} deliveries.
module tb_rom_fetch_unit;
    logic CLK;
    logic RESET_N;

    rom_fetch_unit_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

    rom_fetch_unit #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8),
        .FIFO_DEPTH(4),
        .RESET_ADDR(8'h00)
    ) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .bus    (bus)
    );

    logic [7:0]  rom [256];
    logic [15:0] sb [$];
    int checks    = 0;
    int passed    = 0;
    int failed    = 0;
    int delivered = 0;
    int start     = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) bus.ROM_DATA <= rom[bus.ROM_ADDR];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] a;
            a = first + 8'(i);
            sb.push_back({a, rom[a]});
        end
    endtask

    // Called at a negedge with inputs settled; scores a pop that the next edge will take.
    task automatic cycle();
        logic [15:0] e;
        if (bus.OUT_VALID && bus.OUT_READY && !bus.JUMP) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_addr", bus.OUT_ADDR, e[15:8]);
                chk("sb_data", bus.OUT_DATA, e[7:0]);
            end
            delivered++;
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = i[7:0] ^ 8'hA5;
        RESET_N       = 1'b0;
        bus.ENABLE    = 1'b0;
        bus.JUMP      = 1'b0;
        bus.JUMP_ADDR = 8'h00;
        bus.OUT_READY = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_valid", bus.OUT_VALID, 0);
        chk("rst_data", bus.OUT_DATA, 0);
        chk("rst_addr", bus.OUT_ADDR, 0);
        chk("rst_rom_addr", bus.ROM_ADDR, 8'h00);
        RESET_N = 1'b1;

        // streaming from reset
        sb.delete();
        push_seq(8'h00, 64);
        bus.ENABLE    = 1'b1;
        bus.OUT_READY = 1'b1;
        cycle(); chk("lat_e1_valid", bus.OUT_VALID, 0);
        cycle(); chk("lat_e2_valid", bus.OUT_VALID, 0);
        cycle(); chk("lat_e3_valid", bus.OUT_VALID, 1);
        chk("first_addr", bus.OUT_ADDR, 8'h00);
        chk("first_data", bus.OUT_DATA, 8'hA5);
        start = delivered;
        repeat (20) begin
            cycle();
            chk("stream_valid", bus.OUT_VALID, 1);
        end
        chk("stream_count", delivered - start, 20);

        // asynchronous reset between edges
        #2 RESET_N = 1'b0;
        #1;
        chk("arst_valid", bus.OUT_VALID, 0);
        chk("arst_rom_addr", bus.ROM_ADDR, 8'h00);
        chk("arst_addr", bus.OUT_ADDR, 0);
        chk("arst_data", bus.OUT_DATA, 0);
        bus.ENABLE    = 1'b0;
        bus.OUT_READY = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        sb.delete();
        repeat (4) cycle();
        chk("idle_rom_addr", bus.ROM_ADDR, 8'h00);
        chk("idle_valid", bus.OUT_VALID, 0);

        // jump while idle only moves the pointer
        bus.JUMP_ADDR = 8'h40;
        bus.JUMP      = 1'b1;
        cycle();
        bus.JUMP = 1'b0;
        chk("idle_jump_addr", bus.ROM_ADDR, 8'h40);
        repeat (2) cycle();
        chk("idle_jump_hold", bus.ROM_ADDR, 8'h40);
        chk("idle_jump_valid", bus.OUT_VALID, 0);
        bus.JUMP_ADDR = 8'h00;
        bus.JUMP      = 1'b1;
        cycle();
        bus.JUMP = 1'b0;
        chk("idle_jump_back", bus.ROM_ADDR, 8'h00);

        // back-pressure fills the FIFO, then drain
        bus.ENABLE = 1'b1;
        repeat (10) cycle();
        chk("full_rom_addr", bus.ROM_ADDR, 8'h04);
        chk("full_valid", bus.OUT_VALID, 1);
        chk("full_head_addr", bus.OUT_ADDR, 8'h00);
        chk("full_head_data", bus.OUT_DATA, 8'hA5);
        push_seq(8'h00, 64);
        bus.OUT_READY = 1'b1;
        start = delivered;
        repeat (12) begin
            cycle();
            chk("drain_valid", bus.OUT_VALID, 1);
        end
        chk("drain_count", delivered - start, 12);
        chk("drain_rom_addr", bus.ROM_ADDR, 8'h0F);

        // jump with 2 buffered and 1 in flight
        sb.delete();
        push_seq(8'h80, 64);
        bus.JUMP_ADDR = 8'h80;
        bus.JUMP      = 1'b1;
        cycle();
        bus.JUMP = 1'b0;
        chk("jmp_valid_clr", bus.OUT_VALID, 0);
        chk("jmp_rom_addr", bus.ROM_ADDR, 8'h80);
        cycle(); chk("jmp_e1_valid", bus.OUT_VALID, 0);
        cycle(); chk("jmp_e2_valid", bus.OUT_VALID, 1);
        chk("jmp_addr", bus.OUT_ADDR, 8'h80);
        chk("jmp_data", bus.OUT_DATA, 8'h25);
        start = delivered;
        repeat (8) cycle();
        chk("jmp_count", delivered - start, 8);

        // jump near the top of the address space wraps
        sb.delete();
        push_seq(8'hFE, 64);
        bus.JUMP_ADDR = 8'hFE;
        bus.JUMP      = 1'b1;
        cycle();
        bus.JUMP = 1'b0;
        start = delivered;
        repeat (10) cycle();
        chk("wrap_count", delivered - start, 8);
        chk("wrap_rom_addr", bus.ROM_ADDR, 8'h08);

        // disable mid-stream: one last issue at the exit edge, then drain
        start = delivered;
        bus.ENABLE = 1'b0;
        repeat (6) cycle();
        chk("dis_count", delivered - start, 3);
        chk("dis_valid", bus.OUT_VALID, 0);
        chk("dis_rom_addr", bus.ROM_ADDR, 8'h09);
        start = delivered;
        bus.ENABLE = 1'b1;
        repeat (8) cycle();
        chk("resume_count", delivered - start, 5);
        chk("resume_rom_addr", bus.ROM_ADDR, 8'h10);
        chk("resume_valid", bus.OUT_VALID, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
